// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the TicTacToe board buttons (center, up, down, left, right,
// erase, restart). Every raw push-button goes through the same chain:
//   2-FF synchroniser -> debounce counter -> clean level -> press pulse
// and, for buttons selected in REPEAT_MASK, an auto-repeat FSM that re-issues
// the press pulse while the button stays held. Bits are fully independent.
//
// Bit mapping: 0 center, 1 up, 2 down, 3 left, 4 right, 5 erase, 6 restart.
//
// Ports
//   clk           in   1          system clock, all state on the rising edge
//   rst_n         in   1          asynchronous active-low reset
//   btn_raw       in   NUM_BTN    raw button pins, asynchronous, active-high
//   btn_level     out  NUM_BTN    debounced button state (registered)
//   btn_pulse     out  NUM_BTN    one-cycle press / repeat event (registered)
//   any_pulse     out  1          OR of btn_pulse, same cycle (registered)
//   rpt_state_dbg out  2*NUM_BTN  repeat FSM state per bit, 2 bits each
//                                 (0 idle, 1 delay, 2 repeat); bits without
//                                 auto-repeat always read 0
//
// Debounce timing: a raw change first sampled at edge k reaches the
// synchroniser output after edge k+1; the level changes at edge
// k+2+DEBOUNCE_CYCLES provided the synchronised value kept disagreeing with
// the level the whole time. Any agreeing cycle restarts the count from zero.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int                 NUM_BTN         = 7,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 CNT_W           = 18,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 7'b0011110,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 10000000,
    parameter int                 RPT_W           = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BTN-1:0]   btn_raw,
    output logic [NUM_BTN-1:0]   btn_level,
    output logic [NUM_BTN-1:0]   btn_pulse,
    output logic                 any_pulse,
    output logic [2*NUM_BTN-1:0] rpt_state_dbg
);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam longint RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;

    // The debounce counter runs from 0 up to DEBOUNCE_CYCLES; the level flips
    // on the edge where it sits at that terminal value and the inputs still
    // disagree. Together with the two synchroniser stages this gives the
    // k+2+DEBOUNCE_CYCLES latency.
    localparam logic [CNT_W-1:0] DB_TERM     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] DELAY_TERM  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_TERM = RPT_W'(REPEAT_PERIOD - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks (counters never wrap).
    // -------------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db_min
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_cnt_w
        $error("button_conditioner: CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_rpt_min
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end
    if ((64'd1 << RPT_W) <= 64'(RPT_MAX)) begin : g_chk_rpt_w
        $error("button_conditioner: RPT_W too small for repeat timing");
    end

    // -------------------------------------------------------------------------
    // Shared registers and per-bit combinational results
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_pulse;
    logic               r_any;

    logic [NUM_BTN-1:0] w_toggle;    // level flips on this edge
    logic [NUM_BTN-1:0] w_rise;      // press edge
    logic [NUM_BTN-1:0] w_rpt_fire;  // auto-repeat event
    logic [NUM_BTN-1:0] w_event;     // anything that produces a pulse

    // 2-FF synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-button debounce and auto-repeat
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic [CNT_W-1:0] r_db_cnt;
        logic             w_differ;

        assign w_differ     = r_sync2[gi] ^ r_level[gi];
        assign w_toggle[gi] = w_differ && (r_db_cnt == DB_TERM);

        // Counter only advances across an unbroken run of disagreeing cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db_cnt <= '0;
            end else if (!w_differ || w_toggle[gi]) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end

        if (REPEAT_MASK[gi]) begin : g_rpt
            rpt_state_t       r_state;
            rpt_state_t       w_state_nxt;
            logic [RPT_W-1:0] r_rpt_cnt;
            logic [RPT_W-1:0] w_rpt_cnt_nxt;
            logic             w_fall;
            logic             w_fire;

            assign w_fall = w_toggle[gi] & r_level[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state   <= RPT_IDLE;
                    r_rpt_cnt <= '0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_rpt_cnt <= w_rpt_cnt_nxt;
                end
            end

            always_comb begin
                w_state_nxt   = r_state;
                w_rpt_cnt_nxt = r_rpt_cnt;
                w_fire        = 1'b0;
                if (w_fall) begin
                    // Release wins over a repeat hit on the same edge, so a
                    // released button never emits a trailing repeat.
                    w_state_nxt   = RPT_IDLE;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    case (r_state)
                        RPT_IDLE: begin
                            if (w_rise[gi]) begin
                                w_state_nxt   = RPT_DELAY;
                                w_rpt_cnt_nxt = '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (r_rpt_cnt == DELAY_TERM) begin
                                w_fire        = 1'b1;
                                w_state_nxt   = RPT_REPEAT;
                                w_rpt_cnt_nxt = '0;
                            end else begin
                                w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (r_rpt_cnt == PERIOD_TERM) begin
                                w_fire        = 1'b1;
                                w_rpt_cnt_nxt = '0;
                            end else begin
                                w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt   = RPT_IDLE;
                            w_rpt_cnt_nxt = '0;
                        end
                    endcase
                end
            end

            assign w_rpt_fire[gi]           = w_fire;
            assign rpt_state_dbg[2*gi +: 2] = r_state;
        end else begin : g_no_rpt
            assign w_rpt_fire[gi]           = 1'b0;
            assign rpt_state_dbg[2*gi +: 2] = RPT_IDLE;
        end
    end

    assign w_rise  = w_toggle & ~r_level;
    assign w_event = w_rise | w_rpt_fire;

    // -------------------------------------------------------------------------
    // Output registers: level, pulse and the combined pulse all update on the
    // same edge, so btn_pulse lines up with the rising btn_level.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_pulse <= '0;
            r_any   <= 1'b0;
        end else begin
            r_level <= r_level ^ w_toggle;
            r_pulse <= w_event;
            r_any   <= |w_event;
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;
    assign any_pulse = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for button_conditioner with short timing (debounce 4, repeat 20/8).
// A behavioural model derives level, pulse and repeat state from the window
// of raw samples and the elapsed time since the press; a compare process
// checks the DUT against it every cycle, and directed tests pin exact pulse
// edges with hand-computed values.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int              NB   = 7;
    localparam int              DB   = 4;
    localparam int              CW   = 3;
    localparam int              RD   = 20;
    localparam int              RP   = 8;
    localparam int              RW   = 5;
    localparam logic [NB-1:0]   MASK = 7'b0011110;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic [NB-1:0]   btn_raw = '0;
    logic [NB-1:0]   btn_level;
    logic [NB-1:0]   btn_pulse;
    logic            any_pulse;
    logic [2*NB-1:0] rpt_state_dbg;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW),
        .REPEAT_MASK    (MASK),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .RPT_W          (RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_pulse    (btn_pulse),
        .any_pulse    (any_pulse),
        .rpt_state_dbg(rpt_state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;  // number of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips when the DB+1 samples ending two edges back all oppose it.
    // Pulses: on the press edge, then (repeat bits) at elapsed RD, RD+RP, ...
    logic [DB+2:0]   m_hist [NB];
    logic [NB-1:0]   m_level;
    logic [NB-1:0]   m_pulse;
    logic [2*NB-1:0] m_state;
    int              m_press_t [NB];

    always @(posedge clk or negedge rst_n) begin
        logic        old;
        logic [DB:0] win;
        int          e;
        if (!rst_n) begin
            m_level = '0;
            m_pulse = '0;
            m_state = '0;
            for (int i = 0; i < NB; i++) begin
                m_hist[i]    = '0;
                m_press_t[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                m_hist[i]  = {m_hist[i][DB+1:0], btn_raw[i]};
                win        = m_hist[i][DB+2:2];
                old        = m_level[i];
                m_pulse[i] = 1'b0;
                if (win == {(DB+1){~old}}) begin
                    m_level[i] = ~old;
                    if (!old) begin
                        m_pulse[i]   = 1'b1;
                        m_press_t[i] = cyc + 1;
                    end
                end else if (MASK[i] && old) begin
                    e = cyc + 1 - m_press_t[i];
                    if (e >= RD && ((e - RD) % RP) == 0) m_pulse[i] = 1'b1;
                end
                if (MASK[i] && m_level[i])
                    m_state[2*i +: 2] = ((cyc + 1 - m_press_t[i]) < RD) ? 2'd1 : 2'd2;
                else
                    m_state[2*i +: 2] = 2'd0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("level", 32'(btn_level), 32'(m_level));
        check("pulse", 32'(btn_pulse), 32'(m_pulse));
        check("any",   32'(any_pulse), 32'(|m_pulse));
        check("rpt_state", 32'(rpt_state_dbg), 32'(m_state));
    end

    // ---------------- pulse monitor / scoreboard ----------------
    typedef struct packed {
        logic [31:0]   t;
        logic [NB-1:0] p;
        logic          a;
    } ev_t;

    ev_t         ev_q [$];
    logic [31:0] exp_q [$];  // expected pulse edges for the bit under test

    always @(negedge clk) begin
        ev_t ev;
        if (btn_pulse != '0 || any_pulse) begin
            ev.t = 32'(cyc);
            ev.p = btn_pulse;
            ev.a = any_pulse;
            ev_q.push_back(ev);
        end
    end

    task automatic check_pulses(input string name, input int b);
        logic [31:0] act_q [$];
        foreach (ev_q[j]) if (ev_q[j].p[b]) act_q.push_back(ev_q[j].t);
        check({name, "_cnt"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++)
            if (j < act_q.size()) check({name, "_edge"}, act_q[j], exp_q[j]);
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Hold bit b high for n samples; k is the first sampling edge.
    task automatic press_for(input int b, input int n, output int k);
        btn_raw[b] = 1'b1;
        k = cyc + 1;
        tick(n);
        btn_raw[b] = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int          k;
        int          k2;
        int          n_any;
        logic [5:0]  pat;

        tick(3);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_pulse", 32'(btn_pulse), 32'd0);
        check("reset_any",   32'(any_pulse), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Clean press on center, 50 samples.
        ev_q.delete();
        btn_raw[0] = 1'b1;
        k = cyc + 1;
        tick(6);                                   // now just after edge k+5
        check("clean_pre", 32'(btn_level[0]), 32'd0);
        tick(1);                                   // edge k+6
        check("clean_rise", 32'(btn_level[0]), 32'd1);
        tick(43);                                  // edge k+49
        btn_raw[0] = 1'b0;
        tick(15);
        check("clean_released", 32'(btn_level[0]), 32'd0);
        exp_q.push_back(32'(k + 6));
        check_pulses("clean", 0);

        // Center held 60 samples: single pulse, no repeat.
        ev_q.delete();
        press_for(0, 60, k);
        tick(15);
        exp_q.push_back(32'(k + 6));
        check_pulses("center_hold", 0);

        // Glitch on erase: 3 samples high.
        ev_q.delete();
        press_for(5, 3, k);
        tick(12);
        check("glitch_level", 32'(btn_level[5]), 32'd0);
        check_pulses("glitch", 5);

        // Bounce on restart: 1,0,1,1,0,1 then held.
        ev_q.delete();
        pat = 6'b101101;
        k = cyc + 1;
        for (int j = 0; j < 6; j++) begin
            btn_raw[6] = pat[j];
            tick(1);
        end
        tick(20);
        btn_raw[6] = 1'b0;
        tick(15);
        exp_q.push_back(32'(k + 5 + 6));
        check_pulses("bounce", 6);

        // Auto-repeat on up, held 58 samples: press P=k+6, repeats P+20, +8...
        ev_q.delete();
        press_for(1, 58, k);
        tick(15);
        exp_q.push_back(32'(k + 6));
        exp_q.push_back(32'(k + 26));
        exp_q.push_back(32'(k + 34));
        exp_q.push_back(32'(k + 42));
        exp_q.push_back(32'(k + 50));
        exp_q.push_back(32'(k + 58));
        check_pulses("repeat", 1);

        // Simultaneous press on down and erase.
        ev_q.delete();
        btn_raw[2] = 1'b1;
        btn_raw[5] = 1'b1;
        k = cyc + 1;
        tick(10);
        btn_raw[2] = 1'b0;
        btn_raw[5] = 1'b0;
        tick(15);
        n_any = 0;
        foreach (ev_q[j]) if (ev_q[j].a) n_any++;
        check("simul_any_cnt", 32'(n_any), 32'd1);
        exp_q.push_back(32'(k + 6));
        check_pulses("simul_b2", 2);
        exp_q.push_back(32'(k + 6));
        check_pulses("simul_b5", 5);

        // Reset while left is repeating and right is mid-debounce.
        btn_raw[3] = 1'b1;
        tick(40);
        btn_raw[4] = 1'b1;
        tick(2);
        check("pre_reset_level3", 32'(btn_level[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(btn_level), 32'd0);
        check("async_rst_pulse", 32'(btn_pulse), 32'd0);
        check("async_rst_any",   32'(any_pulse), 32'd0);
        check("async_rst_state", 32'(rpt_state_dbg), 32'd0);
        tick(3);
        ev_q.delete();
        rst_n = 1'b1;
        k2 = cyc + 1;
        tick(15);
        btn_raw[3] = 1'b0;
        btn_raw[4] = 1'b0;
        tick(15);
        exp_q.push_back(32'(k2 + 6));
        check_pulses("post_reset_b3", 3);
        exp_q.push_back(32'(k2 + 6));
        check_pulses("post_reset_b4", 4);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
